// File: rtl/nn_pkg.sv
// Shared definitions for the neural-layer serializer blocks.
package nn_pkg;

    // Default layer geometry.
    localparam int unsigned NN_DATA_WIDTH = 16;
    localparam int unsigned NN_NEURON_NUM = 30;

    // Scheduler FSM states.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } sched_state_e;

endpackage

// File: rtl/layer_collect_buf.sv
// Collect bank: gathers per-neuron words in any order until every neuron has reported.
module layer_collect_buf
    import nn_pkg::*;
#(
    parameter int unsigned NEURON_NUM = NN_NEURON_NUM,
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NEURON_NUM*DATA_WIDTH-1:0]       layer_output,
    input  logic [NEURON_NUM-1:0]                  layer_output_valid,
    input  logic                                   i_take,
    output logic [NEURON_NUM-1:0][DATA_WIDTH-1:0]  o_merged,
    output logic                                   o_complete,
    output logic                                   o_overflow
);

    logic [NEURON_NUM-1:0]                 r_mask;
    logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] r_words;
    logic                                  r_overflow;
    logic [NEURON_NUM-1:0]                 w_accept;
    logic [NEURON_NUM-1:0]                 w_dup;

    // Merge stored words with newly accepted ones so a completing edge sees the full frame.
    always_comb begin
        w_accept = layer_output_valid & ~r_mask;
        w_dup    = layer_output_valid & r_mask;
        o_merged = r_words;
        for (int i = 0; i < int'(NEURON_NUM); i++) begin
            if (w_accept[i]) begin
                o_merged[i] = layer_output[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        o_complete = &(r_mask | layer_output_valid);
        o_overflow = r_overflow;
    end

    // Mask, storage and sticky overflow; a take clears the mask for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= '0;
            r_words    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_words <= o_merged;
            if (i_take) begin
                r_mask <= '0;
            end else begin
                r_mask <= r_mask | layer_output_valid;
            end
            if (|w_dup) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// Serializes a complete layer frame onto a single word-wide output, one word per cycle.
module layer_scheduler
    import nn_pkg::*;
#(
    parameter int unsigned NEURON_NUM = NN_NEURON_NUM,
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_output,
    input  logic [NEURON_NUM-1:0]            layer_output_valid,
    output logic [DATA_WIDTH-1:0]            next_input,
    output logic                             next_input_valid,
    output logic                             frame_done,
    output logic                             busy,
    output logic                             overflow
);

    localparam int unsigned IdxW = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NEURON_NUM - 1);

    sched_state_e                          r_state;
    sched_state_e                          w_state_d;
    logic [IdxW-1:0]                       r_idx;
    logic [IdxW-1:0]                       w_idx_d;
    logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] r_send_bank;
    logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] w_merged;
    logic                                  w_complete;
    logic                                  w_load;

    layer_collect_buf #(
        .NEURON_NUM (NEURON_NUM),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_collect (
        .clk                (clk),
        .rst                (rst),
        .layer_output       (layer_output),
        .layer_output_valid (layer_output_valid),
        .i_take             (w_load),
        .o_merged           (w_merged),
        .o_complete         (w_complete),
        .o_overflow         (overflow)
    );

    // Next-state and outputs; a completed frame loads only from IDLE or on the last send word.
    always_comb begin
        w_state_d        = r_state;
        w_idx_d          = r_idx;
        w_load           = 1'b0;
        next_input       = '0;
        next_input_valid = 1'b0;
        frame_done       = 1'b0;
        busy             = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_complete) begin
                    w_load    = 1'b1;
                    w_state_d = StSend;
                    w_idx_d   = '0;
                end
            end
            StSend: begin
                next_input       = r_send_bank[r_idx];
                next_input_valid = 1'b1;
                busy             = 1'b1;
                if (r_idx == LastIdx) begin
                    frame_done = 1'b1;
                    w_idx_d    = '0;
                    if (w_complete) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_idx_d = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_idx_d   = '0;
            end
        endcase
    end

    // State, index and send bank registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_send_bank <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            if (w_load) begin
                r_send_bank <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler with NEURON_NUM=4, DATA_WIDTH=16.
module tb_layer_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   layer_output = '0;
    logic [N-1:0]      layer_output_valid = '0;
    logic [DW-1:0]     next_input;
    logic              next_input_valid;
    logic              frame_done;
    logic              busy;
    logic              overflow;

    int n_assert = 0;
    int n_fail   = 0;

    layer_scheduler #(
        .NEURON_NUM (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .layer_output       (layer_output),
        .layer_output_valid (layer_output_valid),
        .next_input         (next_input),
        .next_input_valid   (next_input_valid),
        .frame_done         (frame_done),
        .busy               (busy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(next_input_valid), 32'd0);
        chk({tag, ".data"},  32'(next_input),       32'd0);
        chk({tag, ".done"},  32'(frame_done),       32'd0);
        chk({tag, ".busy"},  32'(busy),             32'd0);
    endtask

    // Check one emitted word in SEND.
    task automatic chk_word(input string tag, input logic [DW-1:0] w, input logic last);
        chk({tag, ".data"},  32'(next_input),       32'(w));
        chk({tag, ".valid"}, 32'(next_input_valid), 32'd1);
        chk({tag, ".busy"},  32'(busy),             32'd1);
        chk({tag, ".done"},  32'(frame_done),       32'(last));
    endtask

    logic [DW-1:0] exp_w [8];

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset.ovf", 32'(overflow), 32'd0);

        // Full frame in one cycle
        layer_output       = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        layer_output_valid = 4'hF;
        tick();
        layer_output_valid = '0;
        exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033; exp_w[3] = 16'h0044;
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("t1.w%0d", k), exp_w[k], k == 3);
            tick();
        end
        chk_idle("t1.after");

        // Out-of-order arrival 2,0,3,1
        layer_output = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
        layer_output_valid = 4'b0100;
        tick();
        layer_output_valid = '0;
        chk_idle("t2.b2");
        layer_output_valid = 4'b0001;
        tick();
        layer_output_valid = '0;
        chk_idle("t2.b0");
        layer_output_valid = 4'b1000;
        tick();
        layer_output_valid = '0;
        chk_idle("t2.b3");
        layer_output       = {16'hDEAD, 16'hDEAD, 16'h1002, 16'hDEAD};
        layer_output_valid = 4'b0010;
        tick();
        layer_output_valid = '0;
        exp_w[0] = 16'h1001; exp_w[1] = 16'h1002; exp_w[2] = 16'h1003; exp_w[3] = 16'h1004;
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("t2.w%0d", k), exp_w[k], k == 3);
            tick();
        end
        chk_idle("t2.after");

        // Back-to-back frames
        layer_output       = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
        layer_output_valid = 4'hF;
        tick();
        layer_output       = {16'hB004, 16'hB003, 16'hB002, 16'hB001};
        exp_w[0] = 16'hA001; exp_w[1] = 16'hA002; exp_w[2] = 16'hA003; exp_w[3] = 16'hA004;
        exp_w[4] = 16'hB001; exp_w[5] = 16'hB002; exp_w[6] = 16'hB003; exp_w[7] = 16'hB004;
        for (int k = 0; k < 8; k++) begin
            chk_word($sformatf("t3.w%0d", k), exp_w[k], (k == 3) || (k == 7));
            tick();
            layer_output_valid = '0;
        end
        chk_idle("t3.after");

        // Duplicate valid on bit 2
        chk("t4.ovf0", 32'(overflow), 32'd0);
        layer_output       = {16'h0000, 16'h0AAA, 16'h0000, 16'h0000};
        layer_output_valid = 4'b0100;
        tick();
        chk("t4.ovf1", 32'(overflow), 32'd0);
        layer_output       = {16'h0000, 16'h0BBB, 16'h0000, 16'h0000};
        tick();
        layer_output_valid = '0;
        chk("t4.ovf2", 32'(overflow), 32'd1);
        chk_idle("t4.wait");
        layer_output       = {16'h0C03, 16'h0CCC, 16'h0C01, 16'h0C00};
        layer_output_valid = 4'b1011;
        tick();
        layer_output_valid = '0;
        exp_w[0] = 16'h0C00; exp_w[1] = 16'h0C01; exp_w[2] = 16'h0AAA; exp_w[3] = 16'h0C03;
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("t4.w%0d", k), exp_w[k], k == 3);
            tick();
        end
        chk_idle("t4.after");
        chk("t4.ovf3", 32'(overflow), 32'd1);

        // Reset mid-SEND
        layer_output       = {16'h5004, 16'h5003, 16'h5002, 16'h5001};
        layer_output_valid = 4'hF;
        tick();
        layer_output_valid = '0;
        chk_word("t5.w0", 16'h5001, 1'b0);
        tick();
        chk_word("t5.w1", 16'h5002, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("t5.rst");
        chk("t5.ovf", 32'(overflow), 32'd0);
        tick();
        chk_idle("t5.rst2");
        layer_output       = {16'h6004, 16'h6003, 16'h6002, 16'h6001};
        layer_output_valid = 4'hF;
        tick();
        layer_output_valid = '0;
        exp_w[0] = 16'h6001; exp_w[1] = 16'h6002; exp_w[2] = 16'h6003; exp_w[3] = 16'h6004;
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("t5.w%0d", k), exp_w[k], k == 3);
            tick();
        end
        chk_idle("t5.after");
        chk("t5.ovf_end", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
